// File: rtl/reg_status_file.sv
// Architectural register file with rename tags, CDB writeback and source read ports.
// Optional macro RSF_CDB_BYPASS_EN forwards a same-cycle CDB result to busy-register reads.
module reg_status_file #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned NUM_CDB  = 3,
    parameter int unsigned NUM_RD   = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic [NUM_CDB-1:0]          cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag_i,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data_i,
    input  logic [1:0]                  disp_valid_i,
    input  logic [2*IDX_W-1:0]          disp_rd_i,
    input  logic [2*TAG_W-1:0]          disp_tag_i,
    input  logic [NUM_RD*IDX_W-1:0]     src_idx_i,
    output logic [NUM_RD-1:0]           src_ready_o,
    output logic [NUM_RD*DATA_W-1:0]    src_val_o,
    output logic [NUM_RD*TAG_W-1:0]     src_tag_o,
    output logic [NUM_REGS-1:0]         reg_busy_o
);

    logic [DATA_W-1:0] val_q [NUM_REGS];
    logic [DATA_W-1:0] val_d [NUM_REGS];
    logic [TAG_W-1:0]  tag_q [NUM_REGS];
    logic [TAG_W-1:0]  tag_d [NUM_REGS];

    // Per-register CDB match, shared by writeback and the optional read bypass.
    logic [NUM_REGS-1:0] wb_hit;
    logic [DATA_W-1:0]   wb_data [NUM_REGS];

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wb_hit[r]  = 1'b0;
            wb_data[r] = '0;
            // Scan from the highest index down so the lowest matching bus wins.
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_valid_i[k] && (tag_q[r] != '0) &&
                    (cdb_tag_i[k*TAG_W +: TAG_W] == tag_q[r])) begin
                    wb_hit[r]  = 1'b1;
                    wb_data[r] = cdb_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            val_d[r] = val_q[r];
            tag_d[r] = tag_q[r];
            if (wb_hit[r]) begin
                val_d[r] = wb_data[r];
                tag_d[r] = '0;
            end
            if (flush_i) begin
                tag_d[r] = '0;
            end else begin
                // Slot 1 is younger, so it is applied last.
                for (int j = 0; j < 2; j++) begin
                    if (disp_valid_i[j] && idx_ok(disp_rd_i[j*IDX_W +: IDX_W]) &&
                        (disp_rd_i[j*IDX_W +: IDX_W] == IDX_W'(r))) begin
                        tag_d[r] = disp_tag_i[j*TAG_W +: TAG_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst_i) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end else begin
                val_q[r] <= val_d[r];
                tag_q[r] <= tag_d[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            reg_busy_o[r] = (tag_q[r] != '0);
        end
    end

    always_comb begin
        logic [IDX_W-1:0] idx;
        idx         = '0;
        src_ready_o = '1;
        src_val_o   = '0;
        src_tag_o   = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            idx = src_idx_i[p*IDX_W +: IDX_W];
            if (idx_ok(idx)) begin
                if (tag_q[idx] == '0) begin
                    src_val_o[p*DATA_W +: DATA_W] = val_q[idx];
                end else begin
`ifdef RSF_CDB_BYPASS_EN
                    if (wb_hit[idx]) begin
                        src_val_o[p*DATA_W +: DATA_W] = wb_data[idx];
                    end else begin
                        src_ready_o[p]              = 1'b0;
                        src_tag_o[p*TAG_W +: TAG_W] = tag_q[idx];
                    end
`else
                    src_ready_o[p]              = 1'b0;
                    src_tag_o[p*TAG_W +: TAG_W] = tag_q[idx];
`endif
                end
            end
        end
    end

endmodule
